// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: width encodings and FSM state codes shared by the MEM-stage access unit
package mem_access_unit_pkg;
   typedef enum logic [2:0] {RD_LB = 3'd0, RD_LH = 3'd1, RD_LW = 3'd2, RD_LBU = 3'd3, RD_LHU = 3'd4} rd_width_e;
   typedef enum logic [1:0] {WR_SB = 2'd0, WR_SH = 2'd1, WR_SW = 2'd2} wr_width_e;
   typedef enum logic [1:0] {MAU_IDLE, MAU_BUSY, MAU_DONE} mau_state_e;
endpackage

// File: rtl/mem_access_unit_lane.sv
// mem_lane_align: byte-lane steering, load extraction/extension and misalign detection
//  in : rd (access is a read), rdwidth, wrwidth, off (addr[1:0]), wdata (rs2), rdata (bus word)
//  out: be, wlane (store data on its lanes), load_ext, ok (width is defined), mis (misaligned)
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic        rd,
   input  logic [2:0]  rdwidth,
   input  logic [1:0]  wrwidth,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wlane,
   output logic [31:0] load_ext,
   output logic        ok,
   output logic        mis
);
   logic byte_sz, half_sz, word_sz;
   logic [31:0] sh;
   always_comb begin
      byte_sz = rd ? (rdwidth == RD_LB || rdwidth == RD_LBU) : (wrwidth == WR_SB);
      half_sz = rd ? (rdwidth == RD_LH || rdwidth == RD_LHU) : (wrwidth == WR_SH);
      // undefined read widths fall through to a word access
      word_sz = ~byte_sz & ~half_sz;
      ok = rd | (wrwidth != 2'd3);
      mis = ok & ((half_sz & off[0]) | (word_sz & |off));
      be = (rd | word_sz) ? 4'hf : half_sz ? (off[1] ? 4'hc : 4'h3) : 4'b0001 << off;
      wlane = word_sz ? wdata : half_sz ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
      // aligned halves sit at off 0 or 2, so one shift serves bytes and halves
      sh = rdata >> {off, 3'b000};
      load_ext = (rdwidth == RD_LB)  ? {{24{sh[7]}}, sh[7:0]} :
                 (rdwidth == RD_LBU) ? {24'd0, sh[7:0]} :
                 (rdwidth == RD_LH)  ? {{16{sh[15]}}, sh[15:0]} :
                 (rdwidth == RD_LHU) ? {16'd0, sh[15:0]} : rdata;
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit with req/ack bus, stall and timeout
//  in : clk, rst (async, active-high), flush, memread, memwrite, rdwidth, wrwidth, addr, wdata,
//       dmem_ack, dmem_rdata
//  out: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data, mem_stall, misalign, bus_err
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [2:0]  rdwidth,
   input  logic [1:0]  wrwidth,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] load_data,
   output logic        mem_stall,
   output logic        misalign,
   output logic        bus_err
);
   localparam int CW = $clog2(TIMEOUT);
   mau_state_e state;
   logic [CW-1:0] cnt;
   logic [31:0] result, l_addr, l_wdata, c_addr, c_wdata, wlane, load_ext;
   logic [2:0] l_rdw, c_rdw;
   logic [1:0] l_wrw, c_wrw;
   logic [3:0] be;
   logic l_rd, l_wr, flushed, busy, c_rd, c_wr, idle_acc, go, tmo, ok, mis;
   mem_lane_align u_lane (
      .rd(c_rd), .rdwidth(c_rdw), .wrwidth(c_wrw), .off(c_addr[1:0]), .wdata(c_wdata),
      .rdata(dmem_rdata), .be(be), .wlane(wlane), .load_ext(load_ext), .ok(ok), .mis(mis)
   );
   // the access is issued straight from the live inputs in IDLE, then from the copy taken
   // at issue so a flush or a changing EX/MEM register cannot disturb the bus cycle
   always_comb begin
      busy = (state == MAU_BUSY);
      c_rd = busy ? l_rd : memread;
      c_wr = busy ? l_wr : memwrite & ~memread;
      c_rdw = busy ? l_rdw : rdwidth;
      c_wrw = busy ? l_wrw : wrwidth;
      c_addr = busy ? l_addr : addr;
      c_wdata = busy ? l_wdata : wdata;
      idle_acc = (state == MAU_IDLE) & ~rst & (memread | memwrite) & ~flush;
      go = idle_acc & ok & ~mis;
      tmo = busy & ~dmem_ack & (cnt == CW'(TIMEOUT - 1));
      dmem_req = go | busy;
      dmem_we = dmem_req & c_wr;
      dmem_addr = dmem_req ? {c_addr[31:2], 2'b00} : '0;
      dmem_be = dmem_req ? be : '0;
      dmem_wdata = dmem_we ? wlane : '0;
      mem_stall = dmem_req;
      misalign = idle_acc & mis;
      bus_err = tmo;
      load_data = (state == MAU_DONE) ? result : '0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= MAU_IDLE;
         cnt <= '0;
         result <= '0;
         flushed <= 1'b0;
         l_rd <= 1'b0;
         l_wr <= 1'b0;
         l_rdw <= '0;
         l_wrw <= '0;
         l_addr <= '0;
         l_wdata <= '0;
      end else begin
         case (state)
            MAU_IDLE: if (go) begin
               state <= MAU_BUSY;
               cnt <= '0;
               flushed <= 1'b0;
               l_rd <= c_rd;
               l_wr <= c_wr;
               l_rdw <= rdwidth;
               l_wrw <= wrwidth;
               l_addr <= addr;
               l_wdata <= wdata;
            end
            MAU_BUSY: begin
               flushed <= flushed | flush;
               if (dmem_ack) begin
                  result <= (flushed | flush) ? '0 : load_ext;
                  state <= MAU_DONE;
               end else if (tmo) begin
                  result <= '0;
                  state <= MAU_DONE;
               end else cnt <= cnt + 1'b1;
            end
            default: state <= MAU_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;
   logic clk = 1'b0, rst, flush, memread, memwrite, dmem_ack;
   logic [2:0] rdwidth;
   logic [1:0] wrwidth;
   logic [31:0] addr, wdata, dmem_rdata, dmem_addr, dmem_wdata, load_data;
   logic dmem_req, dmem_we, mem_stall, misalign, bus_err;
   logic [3:0] dmem_be;
   int checks = 0, failures = 0;
   logic [31:0] exp_q[$];
   always #5 clk = ~clk;
   mem_access_unit #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .flush(flush), .memread(memread), .memwrite(memwrite),
      .rdwidth(rdwidth), .wrwidth(wrwidth), .addr(addr), .wdata(wdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .load_data(load_data), .mem_stall(mem_stall), .misalign(misalign), .bus_err(bus_err)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic idle_in;
      memread = 0; memwrite = 0; flush = 0; dmem_ack = 0;
      rdwidth = 0; wrwidth = 0; addr = 0; wdata = 0; dmem_rdata = 0;
   endtask
   task automatic all_zero(input string tag);
      chk({tag, ":req"}, 32'(dmem_req), 0);
      chk({tag, ":stall"}, 32'(mem_stall), 0);
      chk({tag, ":addr"}, dmem_addr, 0);
      chk({tag, ":be"}, 32'(dmem_be), 0);
      chk({tag, ":wdata"}, dmem_wdata, 0);
      chk({tag, ":we"}, 32'(dmem_we), 0);
      chk({tag, ":misalign"}, 32'(misalign), 0);
      chk({tag, ":bus_err"}, 32'(bus_err), 0);
   endtask
   // ack_at / flush_at: BUSY cycle (1 = first) on which ack / flush is driven, 0 = never
   task automatic do_acc(input string tag, input logic rd, input logic wr, input logic [2:0] rw,
                         input logic [1:0] ww, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int ack_at, input int flush_at,
                         input logic [31:0] exp_ld, input int exp_stall, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd);
      int stalls, err_at;
      logic req_held;
      logic [31:0] sb;
      @(posedge clk); #1;
      memread = rd; memwrite = wr; rdwidth = rw; wrwidth = ww; addr = a; wdata = wd; dmem_rdata = rdat;
      @(negedge clk);
      chk({tag, ":req"}, 32'(dmem_req), 1);
      chk({tag, ":we"}, 32'(dmem_we), 32'(wr & ~rd));
      chk({tag, ":addr"}, dmem_addr, {a[31:2], 2'b00});
      chk({tag, ":be"}, 32'(dmem_be), 32'(exp_be));
      if (wr & ~rd) chk({tag, ":wdata"}, dmem_wdata, exp_wd);
      exp_q.push_back(exp_ld);
      stalls = 1; err_at = 0; req_held = 1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         dmem_ack = (i == ack_at);
         flush = (i == flush_at);
         @(negedge clk);
         if (!mem_stall) break;
         stalls++;
         if (bus_err) err_at = (err_at == 0) ? i : -1;
         if (!dmem_req) req_held = 0;
      end
      chk({tag, ":stall_cycles"}, 32'(stalls), 32'(exp_stall));
      chk({tag, ":req_held"}, 32'(req_held), 1);
      chk({tag, ":bus_err_cycle"}, 32'(err_at), (ack_at == 0) ? 32'd16 : 32'd0);
      chk({tag, ":done_req"}, 32'(dmem_req), 0);
      sb = exp_q.pop_front();
      chk({tag, ":load_data"}, load_data, sb);
      @(posedge clk); #1;
      idle_in();
   endtask
   task automatic no_bus(input string tag, input logic rd, input logic wr, input logic [2:0] rw,
                         input logic [1:0] ww, input logic [31:0] a, input logic exp_mis);
      @(posedge clk); #1;
      memread = rd; memwrite = wr; rdwidth = rw; wrwidth = ww; addr = a; wdata = 32'h5a5a5a5a;
      @(negedge clk);
      chk({tag, ":misalign"}, 32'(misalign), 32'(exp_mis));
      chk({tag, ":req"}, 32'(dmem_req), 0);
      chk({tag, ":stall"}, 32'(mem_stall), 0);
      chk({tag, ":load_data"}, load_data, 0);
      @(posedge clk); #1;
      idle_in();
      @(negedge clk);
      chk({tag, ":misalign_after"}, 32'(misalign), 0);
   endtask
   initial begin
      logic [31:0] sb;
      idle_in();
      rst = 1;
      #12;
      all_zero("reset");
      chk("reset:load_data", load_data, 0);
      @(posedge clk); #1;
      rst = 0;
      do_acc("lw", 1, 0, 3'd2, 2'd0, 32'h100, 0, 32'hdeadbeef, 1, 0, 32'hdeadbeef, 2, 4'hf, 0);
      do_acc("lb", 1, 0, 3'd0, 2'd0, 32'h103, 0, 32'h80112233, 1, 0, 32'hffffff80, 2, 4'hf, 0);
      do_acc("lbu", 1, 0, 3'd3, 2'd0, 32'h103, 0, 32'h80112233, 2, 0, 32'h00000080, 3, 4'hf, 0);
      do_acc("lh", 1, 0, 3'd1, 2'd0, 32'h102, 0, 32'h80112233, 1, 0, 32'hffff8011, 2, 4'hf, 0);
      do_acc("lhu", 1, 0, 3'd4, 2'd0, 32'h100, 0, 32'h80112233, 1, 0, 32'h00002233, 2, 4'hf, 0);
      do_acc("lw_undef", 1, 0, 3'd7, 2'd0, 32'h104, 0, 32'h01234567, 1, 0, 32'h01234567, 2, 4'hf, 0);
      do_acc("rd_wins", 1, 1, 3'd2, 2'd2, 32'h108, 32'h11111111, 32'h0badf00d, 1, 0, 32'h0badf00d, 2, 4'hf, 0);
      do_acc("sh", 0, 1, 3'd0, 2'd1, 32'h202, 32'h0000abcd, 0, 1, 0, 0, 2, 4'hc, 32'habcdabcd);
      do_acc("sb", 0, 1, 3'd0, 2'd0, 32'h201, 32'h12345677, 0, 1, 0, 0, 2, 4'h2, 32'h77777777);
      do_acc("sw", 0, 1, 3'd0, 2'd2, 32'h300, 32'hcafef00d, 0, 1, 0, 0, 2, 4'hf, 32'hcafef00d);
      no_bus("mis_lw", 1, 0, 3'd2, 2'd0, 32'h101, 1);
      no_bus("mis_sh", 0, 1, 3'd0, 2'd1, 32'h203, 1);
      no_bus("undef_wr", 0, 1, 3'd0, 2'd3, 32'h200, 0);
      do_acc("timeout", 1, 0, 3'd2, 2'd0, 32'h400, 0, 32'h12345678, 0, 0, 0, 17, 4'hf, 0);
      do_acc("flush", 1, 0, 3'd2, 2'd0, 32'h500, 0, 32'h77778888, 4, 1, 0, 5, 4'hf, 0);
      @(posedge clk); #1;
      memread = 1; rdwidth = 3'd2; addr = 32'h600; dmem_rdata = 32'h99999999;
      exp_q.push_back(0);
      @(negedge clk);
      chk("rst_mid:req_issue", 32'(dmem_req), 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1;
      #1;
      all_zero("rst_mid");
      sb = exp_q.pop_front();
      chk("rst_mid:load_data", load_data, sb);
      @(posedge clk); #1;
      idle_in();
      rst = 0;
      @(negedge clk);
      all_zero("post_rst");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
